// File: rtl/fft_frame_arbiter_if.sv
// FIFO-style port bundle for one side of the arbiter: a read port (input FIFO) and a write port (output FIFO).
// The master drives the enables and write data; the slave owns the FIFO flags and read data.
interface fft_frame_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] in_real_dout;
    logic [DATA_WIDTH-1:0] in_imag_dout;
    logic                  out_full;
    logic                  out_wr_en;
    logic [DATA_WIDTH-1:0] out_real_din;
    logic [DATA_WIDTH-1:0] out_imag_din;

    modport master (
        input  in_empty, in_real_dout, in_imag_dout, out_full,
        output in_rd_en, out_wr_en, out_real_din, out_imag_din
    );

    modport slave (
        output in_empty, in_real_dout, in_imag_dout, out_full,
        input  in_rd_en, out_wr_en, out_real_din, out_imag_din
    );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one streaming FFT core between two channels.
// A granted channel keeps the core for one full frame in (FEED) and one full frame out (DRAIN).
module fft_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FFT_N      = 16,
    parameter int CNT_W      = $clog2(FFT_N) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    fft_frame_arbiter_if.master  ch0,
    fft_frame_arbiter_if.master  ch1,
    fft_frame_arbiter_if.slave   fft,
    output logic                 grant,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          ch0_frames,
    output logic [15:0]          ch1_frames,
    output logic                 protocol_err
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               protocol_err_q, protocol_err_d;
    logic [15:0]        frames_q [2];
    logic [15:0]        frames_d [2];

    logic [1:0]            ch_in_empty;
    logic [1:0]            ch_out_full;
    logic [1:0]            ch_in_rd_en;
    logic [1:0]            ch_out_wr_en;
    logic [DATA_WIDTH-1:0] ch_in_real  [2];
    logic [DATA_WIDTH-1:0] ch_in_imag  [2];
    logic [DATA_WIDTH-1:0] ch_out_real [2];
    logic [DATA_WIDTH-1:0] ch_out_imag [2];

    assign ch_in_empty = {ch1.in_empty, ch0.in_empty};
    assign ch_out_full = {ch1.out_full, ch0.out_full};
    assign ch_in_real[0] = ch0.in_real_dout;
    assign ch_in_imag[0] = ch0.in_imag_dout;
    assign ch_in_real[1] = ch1.in_real_dout;
    assign ch_in_imag[1] = ch1.in_imag_dout;

    // Only the granted channel ever sees an enable or non-zero write data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        localparam logic SEL = 1'(gi);
        assign ch_in_rd_en[gi]  = (state_q == FEED) && (grant_q == SEL) &&
                                  fft.in_rd_en && !ch_in_empty[gi];
        assign ch_out_wr_en[gi] = (state_q == DRAIN) && (grant_q == SEL) &&
                                  fft.out_wr_en && !ch_out_full[gi];
        assign ch_out_real[gi]  = (grant_q == SEL) ? fft.out_real_din : '0;
        assign ch_out_imag[gi]  = (grant_q == SEL) ? fft.out_imag_din : '0;
    end

    assign ch0.in_rd_en     = ch_in_rd_en[0];
    assign ch1.in_rd_en     = ch_in_rd_en[1];
    assign ch0.out_wr_en    = ch_out_wr_en[0];
    assign ch1.out_wr_en    = ch_out_wr_en[1];
    assign ch0.out_real_din = ch_out_real[0];
    assign ch0.out_imag_din = ch_out_imag[0];
    assign ch1.out_real_din = ch_out_real[1];
    assign ch1.out_imag_din = ch_out_imag[1];

    assign fft.in_empty     = (state_q == FEED)  ? ch_in_empty[grant_q] : 1'b1;
    assign fft.out_full     = (state_q == DRAIN) ? ch_out_full[grant_q] : 1'b1;
    assign fft.in_real_dout = ch_in_real[grant_q];
    assign fft.in_imag_dout = ch_in_imag[grant_q];

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign ch0_frames   = frames_q[0];
    assign ch1_frames   = frames_q[1];
    assign protocol_err = protocol_err_q;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        frame_done_d   = 1'b0;
        frames_d       = frames_q;
        protocol_err_d = protocol_err_q |
                         (fft.out_wr_en & fft.out_full) |
                         (fft.in_rd_en & fft.in_empty);

        case (state_q)
            IDLE: begin
                in_cnt_d = '0;
                // A simultaneous request goes to whoever did not finish the previous frame.
                if (!ch_in_empty[0] && !ch_in_empty[1]) begin
                    grant_d = ~last_grant_q;
                    state_d = FEED;
                end else if (!ch_in_empty[0]) begin
                    grant_d = 1'b0;
                    state_d = FEED;
                end else if (!ch_in_empty[1]) begin
                    grant_d = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (ch_in_rd_en[grant_q]) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == CNT_W'(FFT_N - 1)) begin
                        state_d   = DRAIN;
                        out_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (ch_out_wr_en[grant_q]) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == CNT_W'(FFT_N - 1)) begin
                        frame_done_d      = 1'b1;
                        frames_d[grant_q] = frames_q[grant_q] + 16'd1;
                        last_grant_d      = grant_q;
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            frames_q[0]    <= '0;
            frames_q[1]    <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            frame_done_q   <= frame_done_d;
            protocol_err_q <= protocol_err_d;
            frames_q[0]    <= frames_d[0];
            frames_q[1]    <= frames_d[1];
        end
    end
endmodule
